// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, constants and bit-level helpers for the SHA-256
// round controller.
//   word_t   - 32-bit SHA-256 word
//   wvars_t  - working variables a..h (a in the most significant slot)
//   state_t  - controller states IDLE, LOAD, ROUND, FINAL, OUT
//   K, IV    - round constants and initial hash value
//   big_sigma0/1, small_sigma0/1, ch, maj - round functions built from
//   constant rotates and shifts only.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } wvars_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    OUT
  } state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // ROTR2 ^ ROTR13 ^ ROTR22
  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // ROTR6 ^ ROTR11 ^ ROTR25
  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
// Ports:
//   cur - working variables a..h entering the round
//   k   - round constant K[t]
//   w   - schedule word W[t]
//   nxt - working variables a..h after the round
module sha256_round
  import sha256_pkg::*;
(
  input  wvars_t cur,
  input  word_t  k,
  input  word_t  w,
  output wvars_t nxt
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequences the SHA-256 compression of one 512-bit block
// at a time, chains H across blocks and offers the digest on valid/ready.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   blk_valid/blk_ready   - block handshake (ready only in IDLE, out of reset)
//   blk_data              - 16 big-endian words, word 0 in [511:480]
//   blk_first, blk_last   - start from IV / present digest after this block
//   dig_valid/dig_ready   - digest handshake, digest held until accepted
//   digest                - H0 in [255:224] .. H7 in [31:0], zero outside OUT
//   busy                  - any state other than IDLE
// Build option: define SHA256_TWO_ROUND_EN to run two chained rounds per
// ROUND cycle (ROUND lasts ROUNDS/2 cycles); results are identical.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         busy
);

`ifdef SHA256_TWO_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [6:0] T_LAST = 7'(ROUNDS - STEP);
  localparam logic [6:0] T_STEP = 7'(STEP);

  state_t     state;
  state_t     state_nxt;
  logic [6:0] t;
  logic       first_q;
  logic       last_q;
  word_t      h [8];
  wvars_t     v;
  wvars_t     v_nxt;
  word_t      w [16];
  word_t      w16;
  logic       accept;

  assign accept    = blk_valid && blk_ready;
  assign blk_ready = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign dig_valid = (state == OUT);
  assign digest    = dig_valid ? {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]} : '0;

  // Window w[0..15] holds W[t..t+15]; W[t+16] is produced every round so the
  // expansion needs no special case for t < 16.
  wvars_t r0;
  sha256_round u_round0 (
    .cur (v),
    .k   (K[t[5:0]]),
    .w   (w[0]),
    .nxt (r0)
  );
  assign w16 = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

`ifdef SHA256_TWO_ROUND_EN
  wvars_t r1;
  word_t  w17;
  sha256_round u_round1 (
    .cur (r0),
    .k   (K[t[5:0] + 6'd1]),
    .w   (w[1]),
    .nxt (r1)
  );
  assign w17   = small_sigma1(w[15]) + w[10] + small_sigma0(w[2]) + w[1];
  assign v_nxt = r1;
`else
  assign v_nxt = r0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = ROUND;
      ROUND:   if (t == T_LAST) state_nxt = FINAL;
      FINAL:   state_nxt = last_q ? OUT : IDLE;
      OUT:     if (dig_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      h       <= IV;
      v       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            first_q <= blk_first;
            last_q  <= blk_last;
          end
        end
        LOAD: begin
          t <= '0;
          if (first_q) begin
            v <= {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};
            h <= IV;
          end else begin
            v <= {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
          end
        end
        ROUND: begin
          v <= v_nxt;
          t <= t + T_STEP;
        end
        FINAL: begin
          h[0] <= h[0] + v.a;
          h[1] <= h[1] + v.b;
          h[2] <= h[2] + v.c;
          h[3] <= h[3] + v.d;
          h[4] <= h[4] + v.e;
          h[5] <= h[5] + v.f;
          h[6] <= h[6] + v.g;
          h[7] <= h[7] + v.h;
        end
        default: ;
      endcase
    end
  end

  // Schedule window is pure data: loaded on accept, shifted during ROUND.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 16; i++) w[i] <= blk_data[511 - 32*i -: 32];
    end else if (state == ROUND) begin
`ifdef SHA256_TWO_ROUND_EN
      for (int i = 0; i < 14; i++) w[i] <= w[i+2];
      w[14] <= w16;
      w[15] <= w17;
`else
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w16;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;
`ifdef SHA256_TWO_ROUND_EN
  localparam int LAT = ROUNDS/2 + 2;
  localparam int MID = 16;
`else
  localparam int LAT = ROUNDS + 2;
  localparam int MID = 31;
`endif

  localparam logic [511:0] B_ABC   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  typedef struct {
    logic [255:0] dig;
    int           due;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc;
  int   n;
  logic prev_valid = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic         dig_valid;
  logic         dig_ready = 1'b1;
  logic [255:0] digest;
  logic         busy;

  sha256_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digest    (digest),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: on each new digest presentation, pop and compare value and latency.
  always @(negedge clk) begin
    if (dig_valid === 1'b1 && !prev_valid) begin
      check("digest_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("digest", digest, mon_e.dig);
        check("latency", cyc, mon_e.due);
      end
    end
    prev_valid = (dig_valid === 1'b1);
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [511:0] data, input logic first, input logic last,
                      input logic [255:0] exp_dig, output int acc_edge);
    exp_t e;
    int   k;
    blk_data  = data;
    blk_first = first;
    blk_last  = last;
    blk_valid = 1'b1;
    k = 0;
    while (blk_ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("blk_ready_wait", blk_ready, 1);
    acc_edge = cyc + 1;
    if (last) begin
      e.dig = exp_dig;
      e.due = acc_edge + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain", (sb.size() == 0), 1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_blk_ready", blk_ready, 0);
    check("rst_dig_valid", dig_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_digest", digest, 0);
    rst_n = 1'b1;
    #1;
    check("blk_ready_after_rst", blk_ready, 1);
    @(negedge clk);

    // single block "abc", then empty message (first=1 drops stale chain)
    send(B_ABC, 1'b1, 1'b1, D_ABC, acc);
    drain();
    send(B_EMPTY, 1'b1, 1'b1, D_EMPTY, acc);
    drain();

    // two-block message; block 1 must return to IDLE without a digest
    send(B_TWO1, 1'b1, 1'b0, '0, acc);
    n = 0;
    while (blk_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("nonlast_ready_time", cyc, acc + LAT);
    send(B_TWO2, 1'b0, 1'b1, D_TWO, acc);
    drain();

    // backpressure on the digest
    dig_ready = 1'b0;
    send(B_ABC, 1'b1, 1'b1, D_ABC, acc);
    n = 0;
    while (dig_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_dig_valid", dig_valid, 1);
      check("hold_digest", digest, D_ABC);
      check("hold_blk_ready", blk_ready, 0);
    end
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    check("release_dig_valid", dig_valid, 0);
    check("release_blk_ready", blk_ready, 1);
    check("release_busy", busy, 0);
    check("release_digest", digest, 0);
    dig_ready = 1'b1;
    @(negedge clk);

    // reset in the middle of ROUND at t=30
    send(B_ABC, 1'b1, 1'b1, D_ABC, acc);
    repeat (MID) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_blk_ready", blk_ready, 0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_dig_valid", dig_valid, 0);
    check("midrst_blk_ready", blk_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_blk_ready_rise", blk_ready, 1);
    @(negedge clk);

    // first=0 right after reset chains from the IV
    send(B_ABC, 1'b0, 1'b1, D_ABC, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequences the SHA-256 compression function over one 512-bit message block at a time.
- Generates the 64-word message schedule in a 16-word sliding window.
- Drives one round per clock through the Σ0/Σ1/σ0/σ1 rotate/xor datapath.
- Accumulates the chaining value across blocks and presents the 256-bit digest on a valid/ready output.
- Sits between the padding/block-assembly front end and the digest consumer.

Parameters:
- ROUNDS, 64, number of compression rounds executed; must be even, 2..64. Only 64 is SHA-256 compliant; smaller values are for debug.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- blk_valid  input  1  message block offered
- blk_ready  output  1  controller can accept a block
- blk_data  input  512  block, word 0 in bits [511:480], big-endian words
- blk_first  input  1  sampled with block; 1 = start from the IV, 0 = chain from the current H
- blk_last  input  1  sampled with block; 1 = present the digest after this block
- dig_valid  output  1  digest available
- dig_ready  input  1  consumer accepts the digest
- digest  output  256  H0 in [255:224] .. H7 in [31:0]
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock domain; reset is synchronous, active-low; all state updates on the rising clk edge.
- Reset values:
  - blk_ready=0, dig_valid=0, busy=0, digest=0.
  - State=IDLE; round counter=0.
  - H registers = IV; working vars a..h = 0.
- blk_ready is 1 only in IDLE and only when rst_n=1. It therefore rises the first cycle after reset is released.
- FSM transitions:
  - IDLE -> LOAD on blk_valid&&blk_ready. Latch blk_data into W[0..15] and capture blk_first/blk_last.
  - LOAD (1 cycle): a..h <= blk_first ? IV : H. If blk_first, H <= IV in the same cycle.
  - ROUND: one round per cycle, t=0..ROUNDS-1. T1=h+Σ1(e)+Ch(e,f,g)+K[t]+W[t]; T2=Σ0(a)+Maj(a,b,c). All additions are modulo 2^32. Exits after t=ROUNDS-1.
  - FINAL (1 cycle): Hi <= Hi + working var i, mod 2^32. Then go to OUT if blk_last, else IDLE.
  - OUT: dig_valid=1 and digest=H, held stable until dig_ready. On dig_valid&&dig_ready go to IDLE. dig_ready outside OUT is ignored.
- Message schedule:
  - For t<16, W[t] comes from the window directly.
  - For t>=16, W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16]. The window shifts by one word every round.
  - Only 16 × 32-bit registers are held.
- Latency:
  - Block accepted at edge N.
  - dig_valid high at edge N+ROUNDS+2 for a last block (N+66 at default).
  - blk_ready returns at the same point for a non-last block.
- No back-to-back overlap: the next block is accepted only from IDLE.
- blk_first=1 with H holding a stale chain discards that chain; this is legal.
- blk_first=0 on the first block after reset chains from the IV, which is equivalent to blk_first=1.
- Reset asserted in any state: the next edge returns everything to reset values. A partial block is lost and dig_valid drops immediately.
- blk_valid while blk_ready=0 has no effect. The source must hold its data until handshake.

Optional Feature:
- SHA256_TWO_ROUND_EN:
  - Defined: two chained rounds per ROUND cycle (t, t+1), with the window advancing two words per cycle. ROUND lasts ROUNDS/2 cycles, and last-block latency becomes ROUNDS/2+2 (34 at default).
  - Undefined: one round per cycle as above.
  - Handshakes, reset values and digest results are identical in both modes.

Decomposition:
- sha256_pkg holds:
  - word_t (logic [31:0]) and the K[0:63] constant array
  - IV[0:7]
  - state enum {IDLE, LOAD, ROUND, FINAL, OUT}
  - functions big_sigma0/1, small_sigma0/1, ch, maj, expressed as constant rotates/shifts
- One sub-module, sha256_round: a purely combinational single round taking a..h, K and W and producing the next a..h.
  - Instantiated once, or twice chained under SHA256_TWO_ROUND_EN.

Test Plan:
- Single block "abc" (padded), first=last=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad at N+66.
- Empty message (0x80 followed by zeros, length 0), first=last=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first=1/last=0, then first=0/last=1) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. No dig_valid after block 1.
- Backpressure: "abc" with dig_ready=0 for 20 cycles -> dig_valid and digest stable, blk_ready=0 throughout. A dig_ready pulse gives IDLE with blk_ready=1 on the next cycle.
- Reset mid-ROUND at t=30: rst_n=0 for 1 cycle -> next cycle busy=0, dig_valid=0, blk_ready=0, then 1. A following "abc" block yields the correct digest.
- Under SHA256_TWO_ROUND_EN, rerun scenarios 1 and 3 -> identical digests, with last-block latency of 34 cycles.
